// File: rtl/otp_pkg.sv
// otp_pkg: shared types and constants for the OTP macro sequencer.
//   - otp_state_e : sequencer states
//   - ERR_*       : rsp_err completion codes
//   - DEF_*       : default geometry and pin timing
//   - max4()      : helper for sizing the shared pin-timing counter
package otp_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdSetup,
      StRdStrobe,
      StRdEval,
      StPgSetup,
      StPgPulse,
      StPgHold,
      StDone
   } otp_state_e;

   localparam logic [1:0] ERR_OK      = 2'b00;
   localparam logic [1:0] ERR_VERIFY  = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL = 2'b10;

   localparam int unsigned DEF_ADDR_W    = 7;
   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_T_SETUP   = 2;
   localparam int unsigned DEF_T_RD      = 4;
   localparam int unsigned DEF_T_PGM     = 200;
   localparam int unsigned DEF_T_HOLD    = 2;
   localparam int unsigned DEF_MAX_RETRY = 3;

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/otp_timer.sv
// otp_timer: loadable down-counter with a zero flag.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (clears count)
//   load_i     : load load_val_i this cycle (wins over counting)
//   load_val_i : value to load
//   zero_o     : count is zero
module otp_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/otp_ctrl.sv
// otp_ctrl: command/response sequencer for a one-time-programmable macro.
//   Reads strobe PRD and capture PDOB. Writes pre-read the word, refuse 1->0 changes,
//   then program the missing bits with PWE pulses, verifying after each pulse
//   and retrying up to MAX_RETRY pulses.
//   clk, rst (sync, active-high)
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata/cmd_tm : command port
//   rsp_valid/rsp_rdata/rsp_err                             : completion port
//   otp_pa/otp_pdin/otp_prd/otp_pprog/otp_pwe/otp_ptm       : macro pins (registered)
//   otp_pdob                                                : macro read data
module otp_ctrl
   import otp_pkg::*;
#(
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned T_SETUP   = DEF_T_SETUP,
   parameter int unsigned T_RD      = DEF_T_RD,
   parameter int unsigned T_PGM     = DEF_T_PGM,
   parameter int unsigned T_HOLD    = DEF_T_HOLD,
   parameter int unsigned MAX_RETRY = DEF_MAX_RETRY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [1:0]        cmd_tm,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [1:0]        rsp_err,
   output logic [ADDR_W-1:0] otp_pa,
   output logic [DATA_W-1:0] otp_pdin,
   output logic              otp_prd,
   output logic              otp_pprog,
   output logic              otp_pwe,
   output logic [1:0]        otp_ptm,
   input  logic [DATA_W-1:0] otp_pdob
);

   localparam int unsigned TMR_W   = $clog2(max4(T_PGM, T_RD, T_SETUP, T_HOLD) + 1);
   localparam int unsigned PULSE_W = $clog2(MAX_RETRY + 1);

   localparam logic [TMR_W-1:0]   LD_SETUP = TMR_W'(T_SETUP - 1);
   localparam logic [TMR_W-1:0]   LD_RD    = TMR_W'(T_RD - 1);
   localparam logic [TMR_W-1:0]   LD_PGM   = TMR_W'(T_PGM - 1);
   localparam logic [TMR_W-1:0]   LD_HOLD  = TMR_W'(T_HOLD - 1);
   localparam logic [PULSE_W-1:0] PULSE_MAX = PULSE_W'(MAX_RETRY);

   if (T_SETUP == 0 || T_RD == 0 || T_PGM == 0 || T_HOLD == 0 || MAX_RETRY == 0 ||
       ADDR_W == 0 || DATA_W == 0) begin : g_bad_param
      $error("otp_ctrl: timing, retry and width parameters must be non-zero");
   end

   otp_state_e state_d, state_q;

   logic [ADDR_W-1:0]  addr_d, addr_q;
   logic [DATA_W-1:0]  wdata_d, wdata_q;
   logic [1:0]         tm_d, tm_q;
   logic               write_d, write_q;
   logic [DATA_W-1:0]  cur_d, cur_q;
   logic [DATA_W-1:0]  mask_d, mask_q;
   logic [PULSE_W-1:0] pulses_d, pulses_q;

   logic              cmd_ready_d, cmd_ready_q;
   logic              rsp_valid_d, rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_d, rsp_rdata_q;
   logic [1:0]        rsp_err_d, rsp_err_q;
   logic [ADDR_W-1:0] pa_d, pa_q;
   logic [DATA_W-1:0] pdin_d, pdin_q;
   logic              prd_d, prd_q;
   logic              pprog_d, pprog_q;
   logic              pwe_d, pwe_q;
   logic [1:0]        ptm_d, ptm_q;

   logic             tmr_load;
   logic [TMR_W-1:0] tmr_load_val;
   logic             tmr_zero;

   otp_timer #(
      .WIDTH(TMR_W)
   ) u_timer (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_load_val),
      .zero_o     (tmr_zero)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      tm_d      = tm_q;
      write_d   = write_q;
      cur_d     = cur_q;
      mask_d    = mask_q;
      pulses_d  = pulses_q;
      rsp_err_d = rsp_err_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid && cmd_ready_q) begin
               state_d  = StRdSetup;
               addr_d   = cmd_addr;
               wdata_d  = cmd_wdata;
               tm_d     = cmd_tm;
               write_d  = cmd_write;
               pulses_d = '0;
            end
         end
         StRdSetup: if (tmr_zero) state_d = StRdStrobe;
         StRdStrobe: begin
            if (tmr_zero) begin
               state_d = StRdEval;
               cur_d   = otp_pdob;
            end
         end
         StRdEval: begin
            state_d = StDone;
            if (!write_q || cur_q == wdata_q) begin
               rsp_err_d = ERR_OK;
            end else if ((cur_q & ~wdata_q) != '0) begin
               // A cleared bit before any pulse is a bad request; after one it is a loss.
               rsp_err_d = (pulses_q == '0) ? ERR_ILLEGAL : ERR_VERIFY;
            end else if (pulses_q < PULSE_MAX) begin
               state_d = StPgSetup;
               mask_d  = wdata_q & ~cur_q;
            end else begin
               rsp_err_d = ERR_VERIFY;
            end
         end
         StPgSetup: begin
            if (tmr_zero) begin
               state_d  = StPgPulse;
               pulses_d = pulses_q + 1'b1;
            end
         end
         StPgPulse: if (tmr_zero) state_d = StPgHold;
         StPgHold:  if (tmr_zero) state_d = StRdSetup;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase

      // Timer is reloaded with the dwell of the state being entered.
      tmr_load = (state_d != state_q);
      unique case (state_d)
         StRdSetup, StPgSetup: tmr_load_val = LD_SETUP;
         StRdStrobe:           tmr_load_val = LD_RD;
         StPgPulse:            tmr_load_val = LD_PGM;
         StPgHold:             tmr_load_val = LD_HOLD;
         default:              tmr_load_val = '0;
      endcase

      // Pins are decoded from the next state so they are registered alongside it.
      cmd_ready_d = (state_d == StIdle);
      rsp_valid_d = (state_d == StDone);
      rsp_rdata_d = (state_d == StDone) ? cur_q : rsp_rdata_q;
      prd_d       = (state_d == StRdStrobe);
      pwe_d       = (state_d == StPgPulse);
      pprog_d     = (state_d inside {StPgSetup, StPgPulse, StPgHold});
      pa_d        = (state_d == StIdle) ? '0 : addr_d;
      pdin_d      = pprog_d ? mask_d : '0;
      ptm_d       = (state_d == StIdle) ? 2'b00 : tm_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         tm_q        <= '0;
         write_q     <= 1'b0;
         cur_q       <= '0;
         mask_q      <= '0;
         pulses_q    <= '0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= ERR_OK;
         pa_q        <= '0;
         pdin_q      <= '0;
         prd_q       <= 1'b0;
         pprog_q     <= 1'b0;
         pwe_q       <= 1'b0;
         ptm_q       <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         tm_q        <= tm_d;
         write_q     <= write_d;
         cur_q       <= cur_d;
         mask_q      <= mask_d;
         pulses_q    <= pulses_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         pa_q        <= pa_d;
         pdin_q      <= pdin_d;
         prd_q       <= prd_d;
         pprog_q     <= pprog_d;
         pwe_q       <= pwe_d;
         ptm_q       <= ptm_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign otp_pa    = pa_q;
   assign otp_pdin  = pdin_q;
   assign otp_prd   = prd_q;
   assign otp_pprog = pprog_q;
   assign otp_pwe   = pwe_q;
   assign otp_ptm   = ptm_q;

endmodule

// File: tb/tb_otp_ctrl.sv
// tb_otp_ctrl: scoreboard bench for otp_ctrl with a behavioural OTP macro model.
module tb_otp_ctrl;
   import otp_pkg::*;

   localparam int unsigned AW = 7;
   localparam int unsigned DW = 8;
   localparam int unsigned TS = 2;
   localparam int unsigned TR = 4;
   localparam int unsigned TP = 200;
   localparam int unsigned TH = 2;
   localparam int unsigned MR = 3;
   // Response latency as the edge index (after accept) at which rsp_valid is sampled.
   localparam int RD_LAT = TS + TR + 2;
   localparam int PG_LAT = 2 * TS + TP + TH + TR + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [1:0]    cmd_tm;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_err;
   logic [AW-1:0] otp_pa;
   logic [DW-1:0] otp_pdin, otp_pdob;
   logic          otp_prd, otp_pprog, otp_pwe;
   logic [1:0]    otp_ptm;

   otp_ctrl #(
      .ADDR_W(AW), .DATA_W(DW), .T_SETUP(TS), .T_RD(TR), .T_PGM(TP), .T_HOLD(TH),
      .MAX_RETRY(MR)
   ) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_tm(cmd_tm),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .otp_pa(otp_pa),
      .otp_pdin(otp_pdin), .otp_prd(otp_prd), .otp_pprog(otp_pprog), .otp_pwe(otp_pwe),
      .otp_ptm(otp_ptm), .otp_pdob(otp_pdob)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] rdata;
      logic [1:0]    err;
      int            lat;
      int            acc;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] pdin_q[$];
   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   logic [1:0]    cur_tm = 2'b00;

   // Macro contents as seen by the model of the silicon, and the reference prediction.
   logic [DW-1:0] mac_mem[128];
   logic [DW-1:0] ref_mem[128];
   logic [DW-1:0] stuck[128];   // bits that never program
   logic [DW-1:0] drop1[128];   // bits that fail on the first pulse to that word
   int            mac_np[128];
   int            ref_np[128];

   assign otp_pdob = otp_prd ? mac_mem[otp_pa] : '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_event(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference model: whole-command outcome from the word's current content.
   task automatic predict(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] w,
                          output exp_t e);
      logic [DW-1:0] cur, mask;
      int n;
      cur = ref_mem[a];
      n = 0;
      e.err = ERR_OK;
      if (wr) begin
         if ((cur & ~w) != 0) begin
            e.err = ERR_ILLEGAL;
         end else if (cur != w) begin
            e.err = ERR_VERIFY;
            for (int p = 0; p < int'(MR); p++) begin
               mask = w & ~cur;
               pdin_q.push_back(mask);
               cur = cur | (mask & ~stuck[a] & ~((ref_np[a] == 0) ? drop1[a] : 8'h00));
               ref_np[a]++;
               n++;
               if (cur == w) begin
                  e.err = ERR_OK;
                  break;
               end
            end
            ref_mem[a] = cur;
         end
      end
      e.rdata = cur;
      e.lat = RD_LAT + n * PG_LAT;
      e.acc = 0;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Macro model and pin-rule monitor, sampled mid-cycle.
   initial begin
      logic          pwe_prev, prd_prev, strobe_prev;
      logic [AW-1:0] pa_prev, pg_addr;
      logic [DW-1:0] pdin_prev, pg_mask;
      int            pwe_w, prd_w;
      exp_t          e;
      pwe_prev = 0; prd_prev = 0; strobe_prev = 0; pa_prev = '0; pdin_prev = '0;
      pwe_w = 0; prd_w = 0; pg_addr = '0; pg_mask = '0;
      forever begin
         @(negedge clk);
         // program pulse tracking
         if (otp_pwe && !pwe_prev) begin
            if (pdin_q.size() == 0) fail_event("unexpected_pwe_pulse");
            else check("pulse_pdin", 32'(otp_pdin), 32'(pdin_q.pop_front()));
            pg_mask = otp_pdin;
            pg_addr = otp_pa;
            pwe_w = 1;
         end else if (otp_pwe) begin
            pwe_w++;
         end else if (pwe_prev && otp_pprog) begin
            check("pwe_width", 32'(pwe_w), 32'(TP));
            mac_mem[pg_addr] = mac_mem[pg_addr] | (pg_mask & ~stuck[pg_addr] &
                               ~((mac_np[pg_addr] == 0) ? drop1[pg_addr] : 8'h00));
            mac_np[pg_addr]++;
         end
         // PRD high-time tracking (a reset-truncated strobe is not a timing error)
         if (otp_prd && !prd_prev) prd_w = 1;
         else if (otp_prd) prd_w++;
         else if (prd_prev && cmd_ready == 1'b0 && otp_ptm == cur_tm) begin
            if (!rst) check("prd_width", 32'(prd_w), 32'(TR));
         end
         // pin rules
         check("prd_and_pprog", 32'(otp_prd & otp_pprog), 32'd0);
         check("pwe_without_pprog", 32'(otp_pwe & ~otp_pprog), 32'd0);
         if (!otp_pprog) check("pdin_outside_pg", 32'(otp_pdin), 32'd0);
         if (cmd_ready) check("ptm_in_idle", 32'(otp_ptm), 32'd0);
         if (otp_prd || otp_pwe) begin
            check("ptm_during_strobe", 32'(otp_ptm), 32'(cur_tm));
            if (strobe_prev) begin
               check("pa_stable_in_strobe", 32'(otp_pa), 32'(pa_prev));
               check("pdin_stable_in_strobe", 32'(otp_pdin), 32'(pdin_prev));
            end
         end
         // scoreboard
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               fail_event("unexpected_rsp_valid");
            end else begin
               e = exp_q.pop_front();
               check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
               check("rsp_err", 32'(rsp_err), 32'(e.err));
               check("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
         end
         pwe_prev = otp_pwe;
         prd_prev = otp_prd;
         strobe_prev = otp_prd | otp_pwe;
         pa_prev = otp_pa;
         pdin_prev = otp_pdin;
      end
   end

   // Called on a negedge; returns on a negedge after the command is accepted.
   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] w,
                        input logic [1:0] tm, input bit hammer);
      exp_t e;
      int k;
      k = 0;
      while (!cmd_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!cmd_ready) begin
         fail_event("cmd_ready_timeout");
         return;
      end
      predict(wr, a, w, e);
      cur_tm = tm;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr = a;
      cmd_wdata = w;
      cmd_tm = tm;
      @(negedge clk);
      e.acc = cyc;
      exp_q.push_back(e);
      if (hammer) begin
         // A busy controller must ignore this request entirely.
         cmd_write = 1'b1;
         cmd_wdata = 8'hFF;
         cmd_tm = ~tm;
         repeat (4) @(negedge clk);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      for (int k = 0; k < 3000; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      if (exp_q.size() != 0) begin
         fail_event("rsp_timeout");
         exp_q.delete();
      end
      check("pulses_consumed", 32'(pdin_q.size()), 32'd0);
      pdin_q.delete();
   endtask

   initial begin
      #5000000;
      $display("FAIL global_timeout (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] save_mem, w;
      int save_np, k;
      logic [AW-1:0] a;
      bit wr;
      for (int i = 0; i < 128; i++) begin
         mac_mem[i] = '0; ref_mem[i] = '0; stuck[i] = '0; drop1[i] = '0;
         mac_np[i] = 0; ref_np[i] = 0;
      end
      mac_mem[7'h12] = 8'h5A; ref_mem[7'h12] = 8'h5A;
      drop1[7'h30] = 8'h01;
      stuck[7'h31] = 8'h01;
      stuck[5] = 8'h80;
      drop1[6] = 8'h0F;

      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_tm = '0;
      repeat (3) @(negedge clk);
      check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      check("reset_rsp", 32'({rsp_valid, rsp_rdata, rsp_err}), 32'd0);
      check("reset_pins", 32'({otp_pa, otp_pdin, otp_prd, otp_pprog, otp_pwe, otp_ptm}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", 32'(cmd_ready), 32'd1);

      issue(1'b0, 7'h12, 8'h00, 2'b01, 1'b1); wait_rsp();   // read 0x5A, busy hammer
      issue(1'b1, 7'h20, 8'hF0, 2'b10, 1'b0); wait_rsp();   // program blank word
      issue(1'b1, 7'h20, 8'h0F, 2'b11, 1'b0); wait_rsp();   // illegal 1->0
      issue(1'b1, 7'h30, 8'h03, 2'b01, 1'b0); wait_rsp();   // retry succeeds
      issue(1'b1, 7'h31, 8'h03, 2'b10, 1'b0); wait_rsp();   // stuck bit -> verify fail
      issue(1'b0, 7'h31, 8'h00, 2'b00, 1'b0); wait_rsp();

      // Reset in the middle of a program pulse.
      save_mem = ref_mem[7'h40];
      save_np = ref_np[7'h40];
      issue(1'b1, 7'h40, 8'h3C, 2'b00, 1'b0);
      k = 0;
      while (!otp_pwe && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("pwe_seen_before_abort", 32'(otp_pwe), 32'd1);
      repeat (50) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_pwe_pprog", 32'({otp_pwe, otp_pprog, otp_prd}), 32'd0);
      check("abort_ready_rsp", 32'({cmd_ready, rsp_valid}), 32'd0);
      exp_q.delete();
      pdin_q.delete();
      ref_mem[7'h40] = save_mem;
      ref_np[7'h40] = save_np;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_abort", 32'(cmd_ready), 32'd1);
      repeat (5) @(negedge clk);
      issue(1'b0, 7'h40, 8'h00, 2'b01, 1'b0); wait_rsp();

      for (int n = 0; n < 40; n++) begin
         a = AW'($urandom_range(0, 7));
         wr = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 3) == 0) w = DW'($urandom);
         else w = ref_mem[a] | DW'($urandom);
         issue(wr, a, w, 2'($urandom), 1'($urandom));
         wait_rsp();
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
